hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 4, register-address width; 2**REG_ADDR_W scoreboard entries.
REQ-002 SHALL have parameter NUM_SRC, default 2, range 1..4, number of ID-stage source operands checked.
REQ-003 SHALL have parameter LOAD_LAT, default 1, range 1..4, cycles after EXE before load data is forwardable.
REQ-004 SHALL have parameter PIPE_WB_DIST, default 2, range 1..4, cycles from EXE until the register file is written.
REQ-005 SHALL have a single clock; reset is asynchronous and active-low.
REQ-006 SHALL have clk  input  1  rising-edge clock.
REQ-007 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have id_src  input  NUM_SRC*REG_ADDR_W  source addresses, operand k at bits [k*REG_ADDR_W +: REG_ADDR_W].
REQ-009 SHALL have id_src_valid  input  NUM_SRC  per-operand has_src qualifier.
REQ-010 SHALL have id_fire  input  1  ID instruction advances to EXE this cycle.
REQ-011 SHALL have id_dest  input  REG_ADDR_W  destination of the advancing instruction.
REQ-012 SHALL have id_wb_en  input  1  advancing instruction writes id_dest.
REQ-013 SHALL have id_memread  input  1  advancing instruction is a load.
REQ-014 SHALL have mem_ready  input  1  back-end advancing; 0 freezes all counters.
REQ-015 SHALL have flush  input  1  branch flush; kills in-flight younger writers.
REQ-016 SHALL have hazard_detected  output  1  stall ID/IF, insert bubble.
REQ-017 SHALL have hazard_mask  output  NUM_SRC  per-operand hazard bits.
REQ-018 SHALL have busy  output  1  any scoreboard entry nonzero.

Function
REQ-019 SHALL keep one down-counter per register, width CNT_W = clog2(LOAD_LAT+PIPE_WB_DIST+1).
REQ-020 SHALL drive hazard_mask[k] = id_src_valid[k] AND counter[id_src[k]] != 0, combinationally from current state.
REQ-021 SHALL drive hazard_detected = OR of hazard_mask; busy = OR of all counters nonzero.
REQ-022 SHALL treat id_fire as effective only when hazard_detected=0 (internal gating); gated fire SHALL not update state.
REQ-023 SHALL, on effective fire with id_wb_en=1, load counter[id_dest] with the issue value per REQ-031/032 on the next edge.
REQ-024 SHALL, each edge with mem_ready=1, decrement every nonzero counter by 1; zero counters stay zero (no wrap).
REQ-025 SHALL hold all counters when mem_ready=0; issue loads (REQ-023) still occur.
REQ-026 SHALL give issue-load priority over decrement when both target the same entry in one cycle.
REQ-027 SHALL, on an issue to an entry already nonzero (WAW), overwrite with the new value, never accumulate.
REQ-028 SHALL, on flush=1, clear all counters at the next edge and suppress that cycle's issue load; an entry loaded by an instruction already past EXE is not distinguished (conservative clear is accepted only because flushed writers are younger).
REQ-029 SHALL produce hazard outputs with zero-cycle latency and state update with one-cycle latency.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously clear all counters; hazard_detected=0, hazard_mask=0, busy=0.

Configuration
REQ-031 SHALL, with HAZARD_FWD_EN defined, issue-load LOAD_LAT for loads and 0 (no entry) for ALU writers.
REQ-032 SHALL, without HAZARD_FWD_EN, issue-load PIPE_WB_DIST for ALU writers and LOAD_LAT+PIPE_WB_DIST for loads.

Structure
REQ-033 SHALL take REG_ADDR_W default, CNT_W function and counter typedef from shared package hazard_pkg.
REQ-034 SHALL instantiate sub-module hazard_sb_entry (one load/decrement/clear counter) per register via generate.

Verification
REQ-035 SHALL check reset: rst_n=0 mid-stall with counter[3]=1 -> hazard_detected=0, busy=0 immediately.
REQ-036 SHALL check load-use, FWD_EN, LOAD_LAT=1: load r3 fires, next cycle src0=r3 valid -> hazard_detected=1 for exactly 1 cycle.
REQ-037 SHALL check no-FWD, PIPE_WB_DIST=2: ALU writes r5, dependent src1=r5 -> stall 2 cycles, hazard_mask=2'b10.
REQ-038 SHALL check freeze: load r2 (LOAD_LAT=2), mem_ready=0 for 3 cycles -> stall lasts 2+3 cycles.
REQ-039 SHALL check flush: load r7 then flush=1 with id_fire ALU r7 same cycle -> counter[7]=0, busy=0 next cycle.
REQ-040 SHALL check WAW/priority: load r4 (cnt 4, no FWD) then ALU r4 -> counter[4]=2; id_src_valid=0 on r4 -> no hazard.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the register hazard scoreboard: default address
// width, counter width helper and the widest counter type.
package hazard_pkg;

  localparam int REG_ADDR_W_DEF = 4;

  // Wide enough for LOAD_LAT + PIPE_WB_DIST up to 4 + 4.
  localparam int CNT_W_MAX = 4;

  typedef logic [CNT_W_MAX-1:0] sb_cnt_t;

  function automatic int cnt_width(input int load_lat, input int wb_dist);
    return $clog2(load_lat + wb_dist + 1);
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: a saturating down-counter with clear, load and
// decrement, in that order of priority.
module hazard_sb_entry
  import hazard_pkg::*;
#(
  parameter int CNT_W = cnt_width(1, 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec_en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec_en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register hazard scoreboard for the ID stage. Define HAZARD_FWD_EN when
// the pipeline forwards results, so only load latency needs to be covered.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int NUM_SRC      = 2,
  parameter int LOAD_LAT     = 1,
  parameter int PIPE_WB_DIST = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]            id_src_valid,
  input  logic                          id_fire,
  input  logic [REG_ADDR_W-1:0]         id_dest,
  input  logic                          id_wb_en,
  input  logic                          id_memread,
  input  logic                          mem_ready,
  input  logic                          flush,
  output logic                          hazard_detected,
  output logic [NUM_SRC-1:0]            hazard_mask,
  output logic                          busy
);

  localparam int NUM_ENT = 2 ** REG_ADDR_W;
  localparam int CNT_W   = cnt_width(LOAD_LAT, PIPE_WB_DIST);

`ifdef HAZARD_FWD_EN
  localparam sb_cnt_t LOAD_ISSUE = sb_cnt_t'(LOAD_LAT);
  localparam sb_cnt_t ALU_ISSUE  = '0;
`else
  localparam sb_cnt_t LOAD_ISSUE = sb_cnt_t'(LOAD_LAT + PIPE_WB_DIST);
  localparam sb_cnt_t ALU_ISSUE  = sb_cnt_t'(PIPE_WB_DIST);
`endif

  logic [CNT_W-1:0]   cnt [NUM_ENT];
  logic [NUM_ENT-1:0] entry_nz;
  logic [CNT_W-1:0]   issue_val;
  logic               fire_eff;

  always_comb begin
    issue_val = id_memread ? LOAD_ISSUE[CNT_W-1:0] : ALU_ISSUE[CNT_W-1:0];
  end

  always_comb begin
    hazard_mask = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      hazard_mask[k] = id_src_valid[k] &&
                       (cnt[id_src[k*REG_ADDR_W +: REG_ADDR_W]] != '0);
    end
  end

  // A stalled instruction must not claim its destination entry.
  assign hazard_detected = |hazard_mask;
  assign fire_eff        = id_fire && !hazard_detected;
  assign busy            = |entry_nz;

  for (genvar e = 0; e < NUM_ENT; e++) begin : g_entry
    hazard_sb_entry #(
      .CNT_W(CNT_W)
    ) u_entry (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (flush),
      .load    (fire_eff && id_wb_en && (id_dest == REG_ADDR_W'(e))),
      .load_val(issue_val),
      .dec_en  (mem_ready),
      .cnt     (cnt[e])
    );
    assign entry_nz[e] = (cnt[e] != '0);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench for hazard_scoreboard; expected stall lengths
// follow whether HAZARD_FWD_EN is defined for the build.
module tb_hazard_scoreboard;

  localparam int REG_ADDR_W   = 4;
  localparam int NUM_SRC      = 2;
  localparam int LOAD_LAT     = 2;
  localparam int PIPE_WB_DIST = 2;

`ifdef HAZARD_FWD_EN
  localparam int LD_CNT  = LOAD_LAT;
  localparam int ALU_CNT = 0;
`else
  localparam int LD_CNT  = LOAD_LAT + PIPE_WB_DIST;
  localparam int ALU_CNT = PIPE_WB_DIST;
`endif

  logic                          clk;
  logic                          rst_n;
  logic [REG_ADDR_W-1:0]         src1, src0;
  logic [NUM_SRC*REG_ADDR_W-1:0] id_src;
  logic [NUM_SRC-1:0]            id_src_valid;
  logic                          id_fire;
  logic [REG_ADDR_W-1:0]         id_dest;
  logic                          id_wb_en;
  logic                          id_memread;
  logic                          mem_ready;
  logic                          flush;
  logic                          hazard_detected;
  logic [NUM_SRC-1:0]            hazard_mask;
  logic                          busy;

  typedef struct packed {
    logic [95:0]        label;
    logic               hd;
    logic [NUM_SRC-1:0] mask;
    logic               busy;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  event sample_ev;

  assign id_src = {src1, src0};

  hazard_scoreboard #(
    .REG_ADDR_W  (REG_ADDR_W),
    .NUM_SRC     (NUM_SRC),
    .LOAD_LAT    (LOAD_LAT),
    .PIPE_WB_DIST(PIPE_WB_DIST)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_src         (id_src),
    .id_src_valid   (id_src_valid),
    .id_fire        (id_fire),
    .id_dest        (id_dest),
    .id_wb_en       (id_wb_en),
    .id_memread     (id_memread),
    .mem_ready      (mem_ready),
    .flush          (flush),
    .hazard_detected(hazard_detected),
    .hazard_mask    (hazard_mask),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input exp_t e);
    vectors++;
    if ({hazard_detected, hazard_mask, busy} !== {e.hd, e.mask, e.busy}) begin
      miscompares++;
      $display("[TB] FAIL %0s: got hd=%b mask=%b busy=%b, expected hd=%b mask=%b busy=%b",
               e.label, hazard_detected, hazard_mask, busy, e.hd, e.mask, e.busy);
    end
  endtask

  task automatic pushExpect(input logic ehd, input logic [NUM_SRC-1:0] emask,
                            input logic ebusy, input logic [95:0] label);
    exp_t e;
    e.label = label;
    e.hd    = ehd;
    e.mask  = emask;
    e.busy  = ebusy;
    exp_q.push_back(e);
  endtask

  // Drives one cycle of ID/back-end inputs and records what the outputs must be.
  task automatic applyStimulus(
    input logic [REG_ADDR_W-1:0] s1, input logic [REG_ADDR_W-1:0] s0,
    input logic [NUM_SRC-1:0] sv, input logic fire, input logic [REG_ADDR_W-1:0] dest,
    input logic wb, input logic rd, input logic mr, input logic fl,
    input logic ehd, input logic [NUM_SRC-1:0] emask, input logic ebusy,
    input logic [95:0] label);
    @(posedge clk);
    #1;
    src1         = s1;
    src0         = s0;
    id_src_valid = sv;
    id_fire      = fire;
    id_dest      = dest;
    id_wb_en     = wb;
    id_memread   = rd;
    mem_ready    = mr;
    flush        = fl;
    pushExpect(ehd, emask, ebusy, label);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk or sample_ev);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    src1 = '0; src0 = '0; id_src_valid = '0; id_fire = 1'b0; id_dest = '0;
    id_wb_en = 1'b0; id_memread = 1'b0; mem_ready = 1'b1; flush = 1'b0;
    rst_n = 1'b0;
    pushExpect(1'b0, 2'b00, 1'b0, "reset");
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Load-use on r3; the stalled instruction's load to r9 must be dropped.
    applyStimulus(4'd0, 4'd0, 2'b00, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, "ld_r3");
    for (int i = 0; i < LD_CNT; i++)
      applyStimulus(4'd0, 4'd3, 2'b01, 1'b1, 4'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, "ld_use");
    applyStimulus(4'd0, 4'd3, 2'b01, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, "ld_use_end");

    // ALU writer r5 consumed on operand 1 only.
    applyStimulus(4'd0, 4'd0, 2'b00, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, "alu_r5");
    for (int i = 0; i < ALU_CNT; i++)
      applyStimulus(4'd5, 4'd0, 2'b11, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, "alu_use");
    applyStimulus(4'd5, 4'd0, 2'b11, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, "alu_use_end");

    // Back-end freeze stretches the load-use stall by the frozen cycles.
    applyStimulus(4'd0, 4'd0, 2'b00, 1'b1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, "ld_r2");
    for (int i = 0; i < 3; i++)
      applyStimulus(4'd0, 4'd2, 2'b01, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, "freeze");
    for (int i = 0; i < LD_CNT; i++)
      applyStimulus(4'd0, 4'd2, 2'b01, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, "thaw");
    applyStimulus(4'd0, 4'd2, 2'b01, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, "freeze_end");

    // Flush clears r7 and drops the ALU issue to r7 in the same cycle.
    applyStimulus(4'd0, 4'd0, 2'b00, 1'b1, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, "ld_r7");
    applyStimulus(4'd0, 4'd0, 2'b00, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, "flush");
    applyStimulus(4'd0, 4'd7, 2'b01, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, "post_flush");

    // WAW: the ALU issue to r4 overwrites the pending load count.
    applyStimulus(4'd0, 4'd0, 2'b00, 1'b1, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, "ld_r4");
    applyStimulus(4'd0, 4'd0, 2'b00, 1'b1, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, "alu_r4");
    applyStimulus(4'd4, 4'd4, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00,
                  1'(ALU_CNT != 0), "waw_noval");
    for (int i = 1; i < ALU_CNT; i++)
      applyStimulus(4'd0, 4'd4, 2'b01, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, "waw_use");
    applyStimulus(4'd0, 4'd4, 2'b01, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, "waw_end");

    // Both operands hitting the same pending load.
    applyStimulus(4'd0, 4'd0, 2'b00, 1'b1, 4'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, "ld_r6");
    applyStimulus(4'd6, 4'd6, 2'b11, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 1'b1, "dual_use");
    applyStimulus(4'd6, 4'd6, 2'b01, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, "single_use");
    for (int i = 2; i < LD_CNT; i++)
      applyStimulus(4'd0, 4'd0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, "drain");
    applyStimulus(4'd0, 4'd0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, "idle");

    // Asynchronous reset while r3 still has one cycle to go.
    applyStimulus(4'd0, 4'd0, 2'b00, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, "ld_r3_b");
    for (int i = 0; i < LD_CNT - 1; i++)
      applyStimulus(4'd0, 4'd3, 2'b01, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, "pre_rst");
    applyStimulus(4'd0, 4'd3, 2'b01, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, "cnt_one");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    pushExpect(1'b0, 2'b00, 1'b0, "rst_async");
    -> sample_ev;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    applyStimulus(4'd0, 4'd3, 2'b01, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, "post_rst");

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
